// File: rtl/buffer_flow_ctrl.sv
// Flow controller for a K-in/J-out circular word buffer: runs both handshakes,
// drives the buffer's ld/write_add/read_add and tracks occupancy.
module buffer_flow_ctrl #(
  parameter int SIZE     = 16,
  parameter int K        = 4,
  parameter int J        = 4,
  parameter int BIT      = $clog2(SIZE),
  parameter int AF_LEVEL = 12
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           flush,
  input  logic           wr_valid,
  output logic           wr_ready,
  input  logic           rd_ready,
  output logic           rd_valid,
  output logic           ld,
  output logic [BIT-1:0] write_add,
  output logic [BIT-1:0] read_add,
  output logic [BIT:0]   count,
  output logic           full,
  output logic           empty,
  output logic           almost_full,
  output logic           err
);

  localparam logic [BIT:0]          K_P    = (BIT+1)'(K);
  localparam logic [BIT:0]          J_P    = (BIT+1)'(J);
  localparam logic [BIT+1:0]        K_U    = (BIT+2)'(K);
  localparam logic [BIT+1:0]        J_U    = (BIT+2)'(J);
  localparam logic [BIT+1:0]        SIZE_U = (BIT+2)'(SIZE);
  localparam logic [BIT+1:0]        AF_U   = (BIT+2)'(AF_LEVEL);
  localparam logic signed [BIT+1:0] K_S    = (BIT+2)'(K);
  localparam logic signed [BIT+1:0] J_S    = (BIT+2)'(J);
  localparam logic signed [BIT+1:0] SIZE_S = (BIT+2)'(SIZE);

  logic [BIT-1:0] wr_ptr_q, wr_ptr_d;
  logic [BIT-1:0] rd_ptr_q, rd_ptr_d;
  logic [BIT:0]   count_q, count_d;
  logic           err_q, err_d;
  // Remembers that the producer was stalled last cycle, so a drop of wr_valid
  // while its beat is still pending can be flagged.
  logic           pend_q, pend_d;

  logic                  wa, ra, range_bad;
  logic [BIT:0]          wr_sum, rd_sum;
  logic [BIT+1:0]        cnt_ext;
  logic signed [BIT+1:0] cnt_nxt;

  assign cnt_ext     = {1'b0, count_q};
  assign wr_ready    = (cnt_ext + K_U) <= SIZE_U;
  assign rd_valid    = cnt_ext >= J_U;
  assign wa          = wr_valid & wr_ready;
  assign ra          = rd_valid & rd_ready;
  assign ld          = wa & ~flush;
  assign write_add   = wr_ptr_q;
  assign read_add    = rd_ptr_q;
  assign count       = count_q;
  assign full        = cnt_ext == SIZE_U;
  assign empty       = count_q == '0;
  assign almost_full = cnt_ext >= AF_U;
  assign err         = err_q;

  always_comb begin
    wr_sum   = {1'b0, wr_ptr_q} + K_P;
    rd_sum   = {1'b0, rd_ptr_q} + J_P;
    wr_ptr_d = wa ? wr_sum[BIT-1:0] : wr_ptr_q;
    rd_ptr_d = ra ? rd_sum[BIT-1:0] : rd_ptr_q;
    cnt_nxt  = signed'(cnt_ext);
    if (wa) cnt_nxt = cnt_nxt + K_S;
    if (ra) cnt_nxt = cnt_nxt - J_S;
    count_d   = cnt_nxt[BIT:0];
    range_bad = (cnt_nxt < 0) || (cnt_nxt > SIZE_S);
    err_d     = err_q | (pend_q & ~wr_valid) | range_bad;
    pend_d    = wr_valid & ~wr_ready;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
      pend_q   <= 1'b0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
      pend_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      err_q    <= err_d;
      pend_q   <= pend_d;
    end
  end

endmodule

// File: tb/tb_buffer_flow_ctrl.sv
// Bench for buffer_flow_ctrl: instance 0 is K=J=4, instance 1 is K=3/J=2,
// both SIZE=16, checked by vectors, hand sequences and a word-count model.
module tb_buffer_flow_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic wv[2], rr[2], fl[2];
  logic rdy_o[2], rv_o[2], ld_o[2], fu_o[2], em_o[2], af_o[2], er_o[2];
  logic [3:0] wadd[2], radd[2];
  logic [4:0] cnt[2];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  buffer_flow_ctrl #(.SIZE(16), .K(4), .J(4), .AF_LEVEL(12)) dut0 (
    .clk(clk), .rst(rst), .flush(fl[0]), .wr_valid(wv[0]), .wr_ready(rdy_o[0]),
    .rd_ready(rr[0]), .rd_valid(rv_o[0]), .ld(ld_o[0]), .write_add(wadd[0]),
    .read_add(radd[0]), .count(cnt[0]), .full(fu_o[0]), .empty(em_o[0]),
    .almost_full(af_o[0]), .err(er_o[0]));

  buffer_flow_ctrl #(.SIZE(16), .K(3), .J(2), .AF_LEVEL(12)) dut1 (
    .clk(clk), .rst(rst), .flush(fl[1]), .wr_valid(wv[1]), .wr_ready(rdy_o[1]),
    .rd_ready(rr[1]), .rd_valid(rv_o[1]), .ld(ld_o[1]), .write_add(wadd[1]),
    .read_add(radd[1]), .count(cnt[1]), .full(fu_o[1]), .empty(em_o[1]),
    .almost_full(af_o[1]), .err(er_o[1]));

  // Reference model: total words ever written and read since the last clear.
  int  MK[2] = '{4, 3};
  int  MJ[2] = '{4, 2};
  int  wtot[2], rtot[2];
  bit  merr[2], mstall[2];

  function automatic int mcount(input int i);
    return wtot[i] - rtot[i];
  endfunction
  function automatic bit mready(input int i);
    return (16 - mcount(i)) >= MK[i];
  endfunction
  function automatic bit mvalid(input int i);
    return mcount(i) >= MJ[i];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 2; i++) begin
      wtot[i] = 0; rtot[i] = 0; merr[i] = 0; mstall[i] = 0;
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      automatic bit r = mready(i);
      automatic bit v = mvalid(i);
      if (fl[i]) begin
        wtot[i] = 0; rtot[i] = 0; merr[i] = 0; mstall[i] = 0;
      end else begin
        if (wv[i] && r) wtot[i] += MK[i];
        if (rr[i] && v) rtot[i] += MJ[i];
        if (mstall[i] && !wv[i]) merr[i] = 1;
        mstall[i] = wv[i] && !r;
      end
    end
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic check_all(input int i);
    automatic int c = mcount(i);
    chk($sformatf("i%0d count", i), int'(cnt[i]), c);
    chk($sformatf("i%0d write_add", i), int'(wadd[i]), wtot[i] % 16);
    chk($sformatf("i%0d read_add", i), int'(radd[i]), rtot[i] % 16);
    chk($sformatf("i%0d wr_ready", i), int'(rdy_o[i]), int'(mready(i)));
    chk($sformatf("i%0d rd_valid", i), int'(rv_o[i]), int'(mvalid(i)));
    chk($sformatf("i%0d full", i), int'(fu_o[i]), int'(c == 16));
    chk($sformatf("i%0d empty", i), int'(em_o[i]), int'(c == 0));
    chk($sformatf("i%0d almost_full", i), int'(af_o[i]), int'(c >= 12));
    chk($sformatf("i%0d err", i), int'(er_o[i]), int'(merr[i]));
    chk($sformatf("i%0d ld", i), int'(ld_o[i]), int'(wv[i] && mready(i) && !fl[i]));
  endtask

  task automatic set_in(input int i, input bit w, input bit r, input bit f);
    wv[i] = w; rr[i] = r; fl[i] = f;
  endtask

  // Inputs are applied just after a rising edge; checks happen at the falling edge.
  task automatic pre();
    @(negedge clk);
  endtask
  task automatic post();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    set_in(0, 0, 0, 0); set_in(1, 0, 0, 0);
    rst = 1'b1;
    model_clear();
    #3;
    rst = 1'b0;
  endtask

  typedef struct {
    bit w, r, f;
    int c, wa, ra;
    bit rdy, rv, fu, em, af, ld;
  } vec_t;
  vec_t vec[13];

  initial begin
    rst = 1'b1;
    set_in(0, 0, 0, 0); set_in(1, 0, 0, 0);
    model_clear();
    //          w r f  cnt wa ra  rdy rv fu em af ld
    vec[0]  = '{1, 0, 0,  0,  0,  0, 1, 0, 0, 1, 0, 1};
    vec[1]  = '{1, 0, 0,  4,  4,  0, 1, 1, 0, 0, 0, 1};
    vec[2]  = '{1, 0, 0,  8,  8,  0, 1, 1, 0, 0, 0, 1};
    vec[3]  = '{1, 0, 0, 12, 12,  0, 1, 1, 0, 0, 1, 1};
    vec[4]  = '{0, 1, 0, 16,  0,  0, 0, 1, 1, 0, 1, 0};
    vec[5]  = '{0, 1, 0, 12,  0,  4, 1, 1, 0, 0, 1, 0};
    vec[6]  = '{0, 1, 0,  8,  0,  8, 1, 1, 0, 0, 0, 0};
    vec[7]  = '{0, 1, 0,  4,  0, 12, 1, 1, 0, 0, 0, 0};
    vec[8]  = '{0, 0, 0,  0,  0,  0, 1, 0, 0, 1, 0, 0};
    vec[9]  = '{1, 0, 0,  0,  0,  0, 1, 0, 0, 1, 0, 1};
    vec[10] = '{1, 0, 0,  4,  4,  0, 1, 1, 0, 0, 0, 1};
    vec[11] = '{1, 0, 1,  8,  8,  0, 1, 1, 0, 0, 0, 0};
    vec[12] = '{0, 0, 0,  0,  0,  0, 1, 0, 0, 1, 0, 0};

    @(posedge clk); #1;
    do_reset();
    pre();
    check_all(0); check_all(1);
    chk("reset write_add", int'(wadd[0]), 0);
    chk("reset rd_valid", int'(rv_o[0]), 0);
    post();

    // Fill, drain and flush on the K=J=4 instance
    do_reset();
    for (int n = 0; n < 13; n++) begin
      set_in(0, vec[n].w, vec[n].r, vec[n].f);
      pre();
      chk($sformatf("v%0d count", n), int'(cnt[0]), vec[n].c);
      chk($sformatf("v%0d write_add", n), int'(wadd[0]), vec[n].wa);
      chk($sformatf("v%0d read_add", n), int'(radd[0]), vec[n].ra);
      chk($sformatf("v%0d wr_ready", n), int'(rdy_o[0]), int'(vec[n].rdy));
      chk($sformatf("v%0d rd_valid", n), int'(rv_o[0]), int'(vec[n].rv));
      chk($sformatf("v%0d full", n), int'(fu_o[0]), int'(vec[n].fu));
      chk($sformatf("v%0d empty", n), int'(em_o[0]), int'(vec[n].em));
      chk($sformatf("v%0d almost_full", n), int'(af_o[0]), int'(vec[n].af));
      chk($sformatf("v%0d ld", n), int'(ld_o[0]), int'(vec[n].ld));
      chk($sformatf("v%0d err", n), int'(er_o[0]), 0);
      post();
    end

    // K=3/J=2: prefill then continuous traffic through the wrap and the stall
    do_reset();
    set_in(1, 1, 0, 0);
    pre(); check_all(1); post();
    for (int n = 0; n < 20; n++) begin
      set_in(1, 1, 1, 0);
      pre();
      check_all(1);
      if (n == 4)  chk("k3 write_add before wrap", int'(wadd[1]), 15);
      if (n == 5)  chk("k3 write_add after wrap", int'(wadd[1]), 2);
      if (n == 11) chk("k3 count at stall", int'(cnt[1]), 14);
      if (n == 11) chk("k3 wr_ready at stall", int'(rdy_o[1]), 0);
      post();
    end

    // Producer drops a stalled beat; err is sticky until flush
    do_reset();
    for (int n = 0; n < 7; n++) begin
      set_in(0, (n < 6), 0, 0);
      pre(); check_all(0); post();
    end
    for (int n = 0; n < 3; n++) begin
      pre(); check_all(0);
      chk("err sticky", int'(er_o[0]), 1);
      post();
    end
    set_in(0, 0, 0, 1);
    pre(); check_all(0); post();
    set_in(0, 0, 0, 0);
    pre(); check_all(0);
    chk("err after flush", int'(er_o[0]), 0);
    post();

    // Asynchronous reset in the middle of a beat
    set_in(0, 1, 0, 0);
    pre(); check_all(0); post();
    set_in(0, 1, 0, 0);
    #2;
    rst = 1'b1;
    #1;
    chk("async rst count", int'(cnt[0]), 0);
    chk("async rst write_add", int'(wadd[0]), 0);
    chk("async rst read_add", int'(radd[0]), 0);
    chk("async rst empty", int'(em_o[0]), 1);
    chk("async rst wr_ready", int'(rdy_o[0]), 1);
    chk("async rst rd_valid", int'(rv_o[0]), 0);
    chk("async rst err", int'(er_o[0]), 0);
    model_clear();
    set_in(0, 0, 0, 0);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Randomized traffic on both instances
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 2; i++) begin
        automatic bit w = mstall[i] ? ($urandom_range(0, 15) != 0) : bit'($urandom_range(0, 1));
        set_in(i, w, bit'($urandom_range(0, 1)), ($urandom_range(0, 39) == 0));
      end
      pre(); check_all(0); check_all(1); post();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
